// File: rtl/sad_group_packer.sv
// Packs a serial stream of SAD results into 6-wide indexed bundles for the 6-to-3 compare tree.
// Two banks (fill, output) decouple the input stream from compare-tree backpressure.
module sad_group_packer #(
   parameter int unsigned       DATA_W     = 32,
   parameter logic [DATA_W-1:0] PAD_VALUE  = 32'hFFFFFFFF,
   parameter logic [DATA_W-1:0] INDEX_BASE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_sad,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [2:0]        out_count,
   output logic [DATA_W-1:0] sad1,
   output logic [DATA_W-1:0] sad2,
   output logic [DATA_W-1:0] sad3,
   output logic [DATA_W-1:0] sad4,
   output logic [DATA_W-1:0] sad5,
   output logic [DATA_W-1:0] sad6,
   output logic [DATA_W-1:0] index1,
   output logic [DATA_W-1:0] index2,
   output logic [DATA_W-1:0] index3,
   output logic [DATA_W-1:0] index4,
   output logic [DATA_W-1:0] index5,
   output logic [DATA_W-1:0] index6
);

   logic [DATA_W-1:0] fill_sad [6];
   logic [DATA_W-1:0] fill_idx [6];
   logic [DATA_W-1:0] out_sad  [6];
   logic [DATA_W-1:0] out_idx  [6];

   logic [2:0]        cnt;
   logic [2:0]        cap_count;
   logic              cap_last;
   logic              fill_complete;
   logic [DATA_W-1:0] idx;

   logic accept;
   logic closing;
   logic transfer;

   assign in_ready = !fill_complete;
   assign accept   = in_valid && !fill_complete;
   assign closing  = accept && (cnt == 3'd5 || in_last);
   // accept and transfer are mutually exclusive: one needs the fill bank open, the other full.
   assign transfer = fill_complete && (!out_valid || out_ready);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt           <= '0;
         fill_complete <= 1'b0;
         cap_count     <= '0;
         cap_last      <= 1'b0;
         idx           <= INDEX_BASE;
      end else if (transfer) begin
         fill_complete <= 1'b0;
         cnt           <= '0;
      end else if (accept) begin
         cnt <= cnt + 3'd1;
         idx <= in_last ? INDEX_BASE : idx + DATA_W'(1);
         if (closing) begin
            fill_complete <= 1'b1;
            cap_count     <= cnt + 3'd1;
            cap_last      <= in_last;
         end
      end
   end

   // NOTE: the fill bank has no reset; every slot is written (data or pad) before a bundle can transfer.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < 6; j++) begin
            if (3'(j) == cnt) begin
               fill_sad[j] <= in_sad;
               fill_idx[j] <= idx;
            end else if (closing && 3'(j) > cnt) begin
               fill_sad[j] <= PAD_VALUE;
               fill_idx[j] <= PAD_VALUE;
            end
         end
      end
   end

   // Output bank: a transfer wins over a plain consume so back-to-back bundles keep out_valid high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_count <= '0;
         for (int j = 0; j < 6; j++) begin
            out_sad[j] <= '0;
            out_idx[j] <= '0;
         end
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_last  <= cap_last;
         out_count <= cap_count;
         for (int j = 0; j < 6; j++) begin
            out_sad[j] <= fill_sad[j];
            out_idx[j] <= fill_idx[j];
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign sad1   = out_sad[0];
   assign sad2   = out_sad[1];
   assign sad3   = out_sad[2];
   assign sad4   = out_sad[3];
   assign sad5   = out_sad[4];
   assign sad6   = out_sad[5];
   assign index1 = out_idx[0];
   assign index2 = out_idx[1];
   assign index3 = out_idx[2];
   assign index4 = out_idx[3];
   assign index5 = out_idx[4];
   assign index6 = out_idx[5];

endmodule

// File: tb/tb_sad_group_packer.sv
// Self-checking bench for sad_group_packer: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a queue-based frame/bundle model.
module tb_sad_group_packer;

   localparam logic [31:0] PAD = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_sad = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic [2:0]  out_count;
   logic [31:0] sad1, sad2, sad3, sad4, sad5, sad6;
   logic [31:0] index1, index2, index3, index4, index5, index6;

   sad_group_packer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sad(in_sad), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_count(out_count),
      .sad1(sad1), .sad2(sad2), .sad3(sad3), .sad4(sad4), .sad5(sad5), .sad6(sad6),
      .index1(index1), .index2(index2), .index3(index3),
      .index4(index4), .index5(index5), .index6(index6)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0][31:0] sad;
      logic [5:0][31:0] idx;
      logic [2:0]       cnt;
      logic             last;
   } bundle_t;

   typedef struct packed {
      logic        v;
      logic [31:0] sad;
      logic        last;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [2:0]  e_cnt;
      logic        e_last;
      logic        chk;
      logic [5:0][31:0] e_sad;
      logic [5:0][31:0] e_idx;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bundle_t read_bundle();
      bundle_t b;
      b.sad  = {sad6, sad5, sad4, sad3, sad2, sad1};
      b.idx  = {index6, index5, index4, index3, index2, index1};
      b.cnt  = out_count;
      b.last = out_last;
      return b;
   endfunction

   task automatic check_bundle(input string p, input bundle_t a, input bundle_t e);
      check({p, "_cnt"}, 32'(a.cnt), 32'(e.cnt));
      check({p, "_last"}, 32'(a.last), 32'(e.last));
      for (int k = 0; k < 6; k++) begin
         check($sformatf("%s_sad%0d", p, k + 1), a.sad[k], e.sad[k]);
         check($sformatf("%s_idx%0d", p, k + 1), a.idx[k], e.idx[k]);
      end
   endtask

   // Reference model: frames are cut into groups of six, indices count per frame, pads fill the tail.
   bundle_t     exp_q[$];
   bundle_t     got_q[$];
   logic [31:0] part_sad[$];
   logic [31:0] part_idx[$];
   logic [31:0] m_idx = '0;
   logic        mon_en = 1'b0;

   task automatic model_clear();
      exp_q.delete(); got_q.delete(); part_sad.delete(); part_idx.delete();
      m_idx = '0;
   endtask

   task automatic model_accept(input logic [31:0] s, input logic l);
      bundle_t b;
      part_sad.push_back(s);
      part_idx.push_back(m_idx);
      m_idx = m_idx + 1;
      if (l || part_sad.size() == 6) begin
         b = '0;
         b.cnt  = 3'(part_sad.size());
         b.last = l;
         for (int k = 0; k < 6; k++) begin
            b.sad[k] = (k < part_sad.size()) ? part_sad[k] : PAD;
            b.idx[k] = (k < part_idx.size()) ? part_idx[k] : PAD;
         end
         exp_q.push_back(b);
         part_sad.delete();
         part_idx.delete();
         if (l) m_idx = '0;
      end
   endtask

   // Inputs only change at posedge+1, so negedge sees the values the next edge will use.
   always @(negedge clk) begin
      if (mon_en) begin
         if (in_valid && in_ready) model_accept(in_sad, in_last);
         if (out_valid && out_ready) got_q.push_back(read_bundle());
      end
   end

   task automatic compare_queues(input string p);
      check({p, "_nbundles"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         check_bundle(p, got_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic send(input logic [31:0] s, input logic l);
      int n = 0;
      in_valid = 1'b1; in_sad = s; in_last = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   function automatic vec_t mk(input logic v, input logic [31:0] s, input logic l, input logic ordy,
                               input logic ir, input logic ov, input logic [2:0] c, input logic el);
      vec_t r;
      r = '0;
      r.v = v; r.sad = s; r.last = l; r.ordy = ordy;
      r.e_ir = ir; r.e_ov = ov; r.e_cnt = c; r.e_last = el;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t    tbl[16];
      bundle_t b, snap;
      logic    held, rdy;
      int      k, c0;
      logic [31:0] s;

      // ---------------- reset state ----------------
      @(posedge clk); #1;
      rst = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sad1", sad1, 32'd0);
      check("rst_index6", index6, 32'd0);

      // ---------------- vector table: basic bundle, partial frame, next-frame index ----------------
      for (int i = 0; i < 5; i++) tbl[i] = mk(1, 32'(10 * (i + 1)), 0, 1, 1, 0, 0, 0);
      tbl[5]  = mk(1, 60, 1, 1, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 1, 1, 6, 1);
      tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 0);
      tbl[8]  = mk(1, 7, 0, 0, 1, 0, 0, 0);
      tbl[9]  = mk(1, 3, 0, 0, 1, 0, 0, 0);
      tbl[10] = mk(1, 9, 0, 0, 1, 0, 0, 0);
      tbl[11] = mk(1, 1, 1, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 1, 1, 4, 1);
      tbl[13] = mk(1, 5, 1, 0, 0, 1, 4, 1);
      tbl[14] = mk(0, 0, 0, 1, 1, 1, 1, 1);
      tbl[15] = mk(0, 0, 0, 1, 1, 0, 0, 0);
      tbl[6].chk = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tbl[6].e_sad[j] = 32'(10 * (j + 1));
         tbl[6].e_idx[j] = 32'(j);
      end
      tbl[12].chk = 1'b1;
      tbl[12].e_sad = {PAD, PAD, 32'd1, 32'd9, 32'd3, 32'd7};
      tbl[12].e_idx = {PAD, PAD, 32'd3, 32'd2, 32'd1, 32'd0};
      tbl[13].chk = 1'b1;
      tbl[13].e_sad = tbl[12].e_sad;
      tbl[13].e_idx = tbl[12].e_idx;
      tbl[14].chk = 1'b1;
      tbl[14].e_sad = {PAD, PAD, PAD, PAD, PAD, 32'd5};
      tbl[14].e_idx = {PAD, PAD, PAD, PAD, PAD, 32'd0};

      for (int i = 0; i < 16; i++) begin
         in_valid = tbl[i].v; in_sad = tbl[i].sad; in_last = tbl[i].last; out_ready = tbl[i].ordy;
         @(posedge clk); #1;
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            check($sformatf("vec%0d_out_count", i), 32'(out_count), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
         end
         if (tbl[i].chk) begin
            b = read_bundle();
            for (int j = 0; j < 6; j++) begin
               check($sformatf("vec%0d_sad%0d", i, j + 1), b.sad[j], tbl[i].e_sad[j]);
               check($sformatf("vec%0d_idx%0d", i, j + 1), b.idx[j], tbl[i].e_idx[j]);
            end
         end
      end
      in_valid = 1'b0; in_last = 1'b0;

      // ---------------- multi-bundle index continuity and throughput ----------------
      do_reset();
      model_clear();
      out_ready = 1'b1;
      mon_en = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 14; i++) send(32'(100 + i), i == 13);
      check("mb_cycles", 32'(cyc - c0), 32'd16);
      repeat (4) begin @(posedge clk); #1; end
      mon_en = 1'b0;
      if (got_q.size() == 3) begin
         check("mb_b0_idx1", got_q[0].idx[0], 32'd0);
         check("mb_b1_idx1", got_q[1].idx[0], 32'd6);
         check("mb_b1_last", 32'(got_q[1].last), 32'd0);
         check("mb_b2_idx2", got_q[2].idx[1], 32'd13);
      end
      compare_queues("mb");

      // ---------------- backpressure: two stages fill, 13th held off ----------------
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_last = 1'b0; in_sad = 200;
      k = 0;
      snap = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) k++;
         in_sad = 32'(200 + k);
         if (c == 6) snap = read_bundle();
         if (c > 6) check($sformatf("bp_hold_c%0d", c), 32'(read_bundle() == snap), 32'd1);
      end
      check("bp_accepted", 32'(k), 32'd12);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_b1_sad1", sad1, 32'd200);
      check("bp_b1_idx6", index6, 32'd5);
      check("bp_b1_cnt", 32'(out_count), 32'd6);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("bp_b2_out_valid", 32'(out_valid), 32'd1);
      check("bp_b2_idx1", index1, 32'd6);
      check("bp_b2_idx6", index6, 32'd11);
      check("bp_b2_sad1", sad1, 32'd206);
      check("bp_b2_in_ready", 32'(in_ready), 32'd1);

      // ---------------- reset mid-operation ----------------
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(32'(300 + i), 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_count", 32'(out_count), 32'd0);
      check("mrst_out_last", 32'(out_last), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      b = read_bundle();
      for (int j = 0; j < 6; j++) begin
         check($sformatf("mrst_sad%0d", j + 1), b.sad[j], 32'd0);
         check($sformatf("mrst_idx%0d", j + 1), b.idx[j], 32'd0);
      end
      out_ready = 1'b1;
      send(77, 1'b1);
      @(posedge clk); #1;
      check("mrst_next_valid", 32'(out_valid), 32'd1);
      check("mrst_next_idx1", index1, 32'd0);
      check("mrst_next_sad1", sad1, 32'd77);
      check("mrst_next_cnt", 32'(out_count), 32'd1);

      // ---------------- idle gaps ----------------
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("gap_in_ready%0d", i), 32'(in_ready), 32'd1);
         in_valid = 1'b1; in_sad = 32'(10 * (i + 1)); in_last = (i == 5);
         @(posedge clk); #1;
         check($sformatf("gap_ov_acc%0d", i), 32'(out_valid), 32'd0);
         in_valid = 1'b0; in_last = 1'b0;
         if (i < 5) begin
            repeat (2) begin
               @(posedge clk); #1;
               check($sformatf("gap_ov_idle%0d", i), 32'(out_valid), 32'd0);
            end
         end
      end
      @(posedge clk); #1;
      check("gap_out_valid", 32'(out_valid), 32'd1);
      b = '0;
      b.cnt = 3'd6; b.last = 1'b1;
      for (int j = 0; j < 6; j++) begin
         b.sad[j] = 32'(10 * (j + 1));
         b.idx[j] = 32'(j);
      end
      check_bundle("gap", read_bundle(), b);

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      model_clear();
      mon_en = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         snap = read_bundle();
         held = out_valid && !out_ready;
         @(posedge clk); #1;
         if (held) begin
            check("rnd_hold_valid", 32'(out_valid), 32'd1);
            check("rnd_hold_bundle", 32'(read_bundle() == snap), 32'd1);
         end
         out_ready = ($urandom % 4) != 0;
         in_valid  = ($urandom % 3) != 0;
         s = $urandom;
         if (s == PAD) s = s - 1;
         in_sad  = s;
         in_last = ($urandom % 8) == 0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      send(32'd1234, 1'b1);
      repeat (10) begin @(posedge clk); #1; end
      mon_en = 1'b0;
      check("rnd_partial_left", 32'(part_sad.size()), 32'd0);
      compare_queues("rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sad_group_packer.md
Name: sad_group_packer

Overview:
Sequential front end for the 6-to-3 SAD compare tree. It takes a serial stream of SAD results from the SAD engine at one per cycle and tags each with a running candidate index. It packs them into 6-wide bundles (sad1..sad6, index1..index6) and presents each bundle to the compare tree over a valid/ready handshake. The final bundle of a frame is padded so the pad entries never win the min reduction.

Parameters:
DATA_W, 32, width of each SAD value and each index
PAD_VALUE, 32'hFFFFFFFF, SAD and index value written into unused slots of a partial final bundle
INDEX_BASE, 0, index assigned to the first candidate of each frame

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  reset, synchronous, active-low
In_Valid  in  1  upstream SAD result valid
In_Ready  out  1  packer can accept a SAD this cycle
In_Sad  in  DATA_W  SAD value
In_Last  in  1  this SAD is the last candidate of the frame
Out_Valid  out  1  bundle on sad1..6/index1..6 is valid
Out_Ready  in  1  compare tree consumes the bundle
Out_Last  out  1  bundle holds the last candidate of the frame
Out_Count  out  3  number of real (non-pad) slots in the bundle, 1..6
sad1..sad6  out  DATA_W each  bundled SADs; slot 1 holds the oldest
index1..index6  out  DATA_W each  candidate indices matching sad1..sad6

Behaviour:
- Reset is synchronous: it acts only at a rising edge with Rst=0.
  - Out_Valid=0, Out_Last=0, Out_Count=0, all sadN/indexN=0.
  - Fill count=0, fill-complete flag=0, index counter=INDEX_BASE.
- In_Ready is combinational from registered state: In_Ready = !fill_complete. It is 1 after the reset edge.
- Accept: In_Valid && In_Ready at an edge.
  - Fill slot[cnt] <= {In_Sad, idx}.
  - cnt++ and idx++. idx wraps modulo 2^DATA_W.
- Bundle completion: an accept with cnt==5 or In_Last=1 sets fill_complete.
  - Slots cnt+1..5 are set to PAD_VALUE for both SAD and index.
  - Captured count = cnt+1. Captured last = In_Last.
  - If In_Last, idx <= INDEX_BASE; otherwise idx continues across bundles.
- Transfer: at an edge with fill_complete && (!Out_Valid || Out_Ready):
  - Fill slots load into sad1..6/index1..6.
  - Out_Count and Out_Last load from the captured values.
  - Out_Valid <= 1, fill_complete <= 0, cnt <= 0.
- Out_Valid clears at Out_Ready && Out_Valid if no transfer happens the same edge. Transfer has priority, so back-to-back bundles stay valid.
- While Out_Valid=1 && Out_Ready=0, all outputs hold stable.
- Latency: final accept of a bundle at edge k; transfer at edge k+1 at the earliest; Out_Valid high after k+1.
- Throughput: with Out_Ready held at 1, the packer accepts 6 inputs per 7 cycles. In_Ready is low for one cycle while a completed bundle transfers.
- Backpressure: there are two stages, the fill bank and the output bank.
  - With Out_Valid=1 and Out_Ready=0, up to 6 more SADs are accepted.
  - In_Ready then stays low until the output bank frees.
- Tie behaviour: the compare tree picks the second operand on equality, so a real SAD equal to PAD_VALUE loses to a pad.
  - The SAD engine guarantees SAD < PAD_VALUE.
  - Pad index PAD_VALUE marks pad slots as invalid downstream.
- In_Last on a full 6th slot: no padding, Out_Count=6, Out_Last=1.
- Reset mid-operation discards any partial fill and the held output bundle. Indices restart at INDEX_BASE.
- In_Valid=0 contributes nothing; a partial fill waits indefinitely (no timeout).

Test Plan:
- Basic bundle: reset, then SADs 10,20,30,40,50,60 on consecutive cycles, In_Last on the 6th, Out_Ready=1 -> one edge after the 6th accept:
  - Out_Valid=1, sad1..6=10..60, index1..6=0..5.
  - Out_Count=6, Out_Last=1.
  - In_Ready low for exactly one cycle after the 6th accept.
- Partial frame: 4 SADs 7,3,9,1, In_Last on the 4th -> sad1..4=7,3,9,1 and index1..4=0..3, Out_Count=4, Out_Last=1. sad5,sad6 and index5,index6=32'hFFFFFFFF. The next frame's first index is 0.
- Multi-bundle index continuity: 14 SADs, In_Last on the 14th -> three bundles:
  - First two: indices 0..5 and 6..11, Out_Last=0.
  - Third: indices 12,13, Out_Count=2, Out_Last=1.
- Backpressure: Out_Ready=0, drive 13 valid SADs continuously ->
  - Bundle 1 holds stable on the outputs.
  - SADs 7..12 are accepted, then In_Ready=0 and the 13th is not taken.
  - Raising Out_Ready for one cycle -> bundle 2 (indices 6..11) loads on that edge with Out_Valid remaining 1. In_Ready returns to 1 the following cycle.
- Reset mid-operation: accept 3 SADs, then Rst=0 for one edge -> Out_Valid=0, all outputs 0, In_Ready=1. The next accepted SAD gets index 0 in slot 1.
- Idle gaps: In_Valid toggling 1,0,0,1,... across 6 SADs -> the bundle is identical to the gap-free case. Out_Valid never asserts before the 6th accept.
